mem_port_arbiter: RTL and testbench

- Arbitrates between the fetch-stage instruction port (mem1) and the MEM-stage data port (mem2) of the pipelined LC-3b core.
- Only one physical memory / L2 interface exists; this block shares it between the two ports.
- Grants one port at a time, forwards that port's request to memory, and routes the memory response back to it.
- Contention is resolved round-robin so neither pipeline stage starves.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle shared by the fetch port, the data port and physical memory.
// The arbiter takes the slave view; the ports plus memory take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  // Handshake: a port raises its strobe with address/wdata and holds all of them
  // stable until it sees a one-cycle resp; pmem_resp likewise completes the
  // granted memory access in exactly the cycle it is high.
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  logic                  arb_busy;
  logic                  arb_grant_d;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output arb_busy, arb_grant_d
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  arb_busy, arb_grant_d
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the fetch (I)
// and MEM-stage (D) ports; one transaction at a time, never preempted.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic       clk,
  input  logic       reset,
  mem_port_arbiter_if.slave bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e                state_q, state_n;
  logic                  last_d_q, last_d_n;
  logic                  i_req, d_req;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [LINE_WIDTH-1:0] wdata_c;

  assign i_req     = bus.i_read;
  assign d_req     = bus.d_read | bus.d_write;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      last_d_q <= last_d_n;
    end
  end

  always_comb begin
    state_n         = state_q;
    last_d_n        = last_d_q;
    addr_c          = '0;
    wdata_c         = '0;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;
    bus.i_resp      = 1'b0;
    bus.d_resp      = 1'b0;
    bus.arb_busy    = 1'b0;
    bus.arb_grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the port not served last wins; a memory resp here is ignored.
        if (i_req && d_req) state_n = last_d_q ? SERVE_I : SERVE_D;
        else if (i_req)     state_n = SERVE_I;
        else if (d_req)     state_n = SERVE_D;
      end
      SERVE_I: begin
        bus.pmem_read = 1'b1;
        addr_c        = bus.i_address;
        bus.arb_busy  = 1'b1;
        if (bus.pmem_resp) begin
          bus.i_resp = ~reset;
          state_n    = IDLE;
          last_d_n   = 1'b0;
        end
      end
      SERVE_D: begin
        // A simultaneous read+write request is carried out as a write.
        bus.pmem_read   = bus.d_read & ~bus.d_write;
        bus.pmem_write  = bus.d_write;
        addr_c          = bus.d_address;
        wdata_c         = bus.d_wdata;
        bus.arb_busy    = 1'b1;
        bus.arb_grant_d = 1'b1;
        if (bus.pmem_resp) begin
          bus.d_resp = ~reset;
          state_n    = IDLE;
          last_d_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.pmem_address = addr_c;
  assign bus.pmem_wdata   = wdata_c;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder knobs
  int          mem_lat    = 3;
  bit          mem_rand   = 1'b0;
  logic [LW-1:0] mem_data = '0;
  bit          force_resp = 1'b0;
  bit          rand_spur  = 1'b0;

  // model: owner 0 = nobody, 1 = fetch port, 2 = data port
  int m_owner  = 0;
  bit m_last_d = 1'b0;

  bit            i_seen = 1'b0, d_seen = 1'b0;
  int            i_cnt = 0, d_cnt = 0;
  logic [LW-1:0] i_cap = '0, d_cap = '0;
  logic [0:0]    exp_q[$];
  logic [0:0]    got_q[$];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_resp(input bit is_d, input int budget, input string name);
    bit got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk); #1;
      if (is_d && d_seen) begin got = 1'b1; d_seen = 1'b0; end
      if (!is_d && i_seen) begin got = 1'b1; i_seen = 1'b0; end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: got no resp, expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_any(input int budget, input string name, output int who);
    who = -1;
    for (int c = 0; c < budget && who < 0; c++) begin
      @(negedge clk); #1;
      if (d_seen) begin who = 1; d_seen = 1'b0; end
      else if (i_seen) begin who = 0; i_seen = 1'b0; end
    end
    n_checks++;
    if (who < 0) begin
      n_fail++;
      $display("FAIL %s: got no resp, expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_order(input string name);
    chk({name, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk(name, got_q[k], exp_q[k]);
  endtask

  // ---------------- physical memory responder ----------------
  initial begin
    int cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      if (!reset && (bus.pmem_read || bus.pmem_write)) begin
        if (cnt >= mem_lat) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_rand ? {$urandom, $urandom, $urandom, $urandom} : mem_data;
          cnt = 0;
        end else cnt++;
      end else begin
        cnt = 0;
        if (force_resp || (rand_spur && $urandom_range(0, 15) == 0)) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
          force_resp = 1'b0;
        end
      end
    end
  end

  // ---------------- model + per-cycle compare ----------------
  initial begin
    logic          e_rd, e_wr, e_ir, e_dr, e_busy, e_gd, wi, wd;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_busy = 0; e_gd = 0; e_addr = '0; e_wd = '0;
      if (m_owner == 1) begin
        e_rd = 1; e_busy = 1; e_addr = bus.i_address;
        e_ir = bus.pmem_resp && !reset;
      end else if (m_owner == 2) begin
        e_wr = bus.d_write; e_rd = bus.d_read && !bus.d_write;
        e_busy = 1; e_gd = 1; e_addr = bus.d_address; e_wd = bus.d_wdata;
        e_dr = bus.pmem_resp && !reset;
      end
      chk("pmem_read", bus.pmem_read, e_rd);
      chk("pmem_write", bus.pmem_write, e_wr);
      chk("pmem_address", bus.pmem_address, e_addr);
      chk("pmem_wdata", bus.pmem_wdata, e_wd);
      chk("i_resp", bus.i_resp, e_ir);
      chk("d_resp", bus.d_resp, e_dr);
      chk("arb_busy", bus.arb_busy, e_busy);
      chk("arb_grant_d", bus.arb_grant_d, e_gd);
      if (e_ir) chk("i_rdata", bus.i_rdata, bus.pmem_rdata);
      if (e_dr) chk("d_rdata", bus.d_rdata, bus.pmem_rdata);
      if (bus.i_resp) begin i_seen = 1; i_cnt++; i_cap = bus.i_rdata; got_q.push_back(1'b0); end
      if (bus.d_resp) begin d_seen = 1; d_cnt++; d_cap = bus.d_rdata; got_q.push_back(1'b1); end
      // advance the model to what the next edge will produce
      wi = bus.i_read;
      wd = bus.d_read || bus.d_write;
      if (reset) begin
        m_owner = 0; m_last_d = 0;
      end else if (m_owner != 0) begin
        if (bus.pmem_resp) begin m_last_d = (m_owner == 2); m_owner = 0; end
      end else if (wi && wd) m_owner = m_last_d ? 1 : 2;
      else if (wi) m_owner = 1;
      else if (wd) m_owner = 2;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int who;
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus.arb_busy, 0);
    chk("reset_grant_d", bus.arb_grant_d, 0);
    chk("reset_pmem_read", bus.pmem_read, 0);

    // solo fetch
    mem_data = {16{8'hA5}}; mem_lat = 3; i_cnt = 0; d_cnt = 0;
    @(posedge clk); #1 bus.i_read = 1; bus.i_address = 16'h0040;
    @(negedge clk); chk("fetch_not_yet", bus.pmem_read, 0);
    @(negedge clk); chk("fetch_strobe", bus.pmem_read, 1);
    chk("fetch_addr", bus.pmem_address, 16'h0040);
    wait_resp(0, 20, "fetch_resp");
    chk("fetch_rdata", i_cap, {16{8'hA5}});
    @(posedge clk); #1 bus.i_read = 0;
    repeat (3) @(negedge clk);
    chk("fetch_once", i_cnt, 1);
    chk("fetch_no_d", d_cnt, 0);

    // solo store
    i_cnt = 0; d_cnt = 0;
    @(posedge clk); #1 bus.d_write = 1; bus.d_address = 16'h1000;
    bus.d_wdata = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    @(negedge clk); @(negedge clk);
    chk("store_write", bus.pmem_write, 1);
    chk("store_addr", bus.pmem_address, 16'h1000);
    chk("store_wdata", bus.pmem_wdata, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321);
    chk("store_grant_d", bus.arb_grant_d, 1);
    wait_resp(1, 20, "store_resp");
    @(posedge clk); #1 bus.d_write = 0;
    repeat (3) @(negedge clk);
    chk("store_once", d_cnt, 1);
    chk("store_no_i", i_cnt, 0);

    // tie right after reset: D first, then I
    do_reset();
    got_q.delete(); exp_q.delete(); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    i_seen = 0; d_seen = 0;
    @(posedge clk); #1 bus.i_read = 1; bus.i_address = 16'h0100;
    bus.d_read = 1; bus.d_address = 16'h0200;
    @(negedge clk); @(negedge clk);
    chk("tie_first_d", bus.arb_grant_d, 1);
    wait_resp(1, 20, "tie_d_resp");
    @(posedge clk); #1 bus.d_read = 0;
    wait_resp(0, 20, "tie_i_resp");
    @(posedge clk); #1 bus.i_read = 0;
    repeat (2) @(negedge clk);
    chk_order("tie_order");

    // sustained contention: alternate D,I,D,I,D,I
    got_q.delete(); exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 1'b1 : 1'b0);
    mem_lat = 1;
    @(posedge clk); #1 bus.i_read = 1; bus.d_read = 1;
    for (int t = 0; t < 6; t++) begin
      wait_any(30, "contend_resp", who);
      @(posedge clk); #1;
      if (who == 0) bus.i_address = 16'(16'h0300 + t);
      if (who == 1) bus.d_address = 16'(16'h0400 + t);
    end
    bus.i_read = 0; bus.d_read = 0;
    repeat (3) @(negedge clk);
    chk_order("contend_order");

    // spurious memory response while idle
    i_cnt = 0; d_cnt = 0;
    @(negedge clk); force_resp = 1;
    @(negedge clk);
    chk("spur_pmem_resp_seen", bus.pmem_resp, 1);
    chk("spur_busy", bus.arb_busy, 0);
    @(negedge clk);
    chk("spur_still_idle", bus.arb_busy, 0);
    chk("spur_no_resp", i_cnt + d_cnt, 0);

    // reset in the middle of a write
    mem_lat = 10; d_cnt = 0;
    @(posedge clk); #1 bus.d_write = 1; bus.d_address = 16'h2000; bus.d_wdata = {4{32'hCAFE_F00D}};
    @(negedge clk); @(negedge clk); @(negedge clk);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    @(posedge clk); #1 reset = 0; bus.d_write = 0;
    @(negedge clk);
    chk("rst_mid_write", bus.pmem_write, 0);
    chk("rst_mid_busy", bus.arb_busy, 0);
    chk("rst_mid_no_resp", d_cnt, 0);
    mem_lat = 2; got_q.delete(); i_seen = 0; d_seen = 0;
    @(posedge clk); #1 bus.i_read = 1; bus.d_read = 1;
    wait_resp(1, 20, "rst_tie_d");
    @(posedge clk); #1 bus.d_read = 0;
    wait_resp(0, 20, "rst_tie_i");
    @(posedge clk); #1 bus.i_read = 0;
    chk("rst_tie_first_d", got_q.size() > 0 ? got_q[0] : 1'bx, 1'b1);

    // randomized traffic
    mem_rand = 1; rand_spur = 1; i_cnt = 0; d_cnt = 0; i_seen = 0; d_seen = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      mem_lat = $urandom_range(0, 3);
      if (!bus.i_read) begin
        if ($urandom_range(0, 2) == 0) begin bus.i_read = 1; bus.i_address = 16'($urandom); end
      end else if (i_seen) begin
        i_seen = 0;
        if ($urandom_range(0, 1) == 1) bus.i_address = 16'($urandom);
        else bus.i_read = 0;
      end
      if (!(bus.d_read || bus.d_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0: begin bus.d_read = 1; bus.d_write = 0; end
            1: begin bus.d_read = 0; bus.d_write = 1; end
            default: begin bus.d_read = 1; bus.d_write = 1; end
          endcase
          bus.d_address = 16'($urandom);
          bus.d_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (d_seen) begin
        d_seen = 0;
        bus.d_read = 0; bus.d_write = 0;
      end
    end
    rand_spur = 0;
    bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
    repeat (8) @(negedge clk);
    chk("random_i_progress", i_cnt > 0, 1);
    chk("random_d_progress", d_cnt > 0, 1);
    chk("random_settles_idle", bus.arb_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
